// File: rtl/tx_byte_fifo.sv
// Byte FIFO plus one-byte-at-a-time transmit pacer feeding uart_tx.
// Define TX_FIFO_CRLF_EN to expand a popped LF (0x0A) into a CR (0x0D) frame then an LF frame.
module tx_byte_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    i_byte,
   input  logic          i_byte_v,
   output logic [7:0]    o_tx_byte,
   output logic          o_tx_dv,
   input  logic          i_tx_active,
   input  logic          i_tx_done,
   output logic [AW:0]   o_count,
   output logic          o_empty,
   output logic          o_full,
   output logic          o_overflow
);

   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACT, WAIT_DONE} state_t;

   state_t          state;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [7:0]      head_c;
   logic            pop_c;
   logic            push_c;
   logic [CW-1:0]   count_n_c;
`ifdef TX_FIFO_CRLF_EN
   logic            lf_pending;
`endif

   assign head_c = mem[rd_ptr];

   // Pop only from IDLE with data stored; a pending LF holds off the next pop.
`ifdef TX_FIFO_CRLF_EN
   assign pop_c  = (state == IDLE) && !o_empty && !lf_pending;
`else
   assign pop_c  = (state == IDLE) && !o_empty;
`endif
   assign push_c = i_byte_v && (!o_full || pop_c);

   always_comb begin
      count_n_c = o_count;
      if (push_c && !pop_c)
         count_n_c = o_count + CW'(1);
      else if (pop_c && !push_c)
         count_n_c = o_count - CW'(1);
   end

   // Storage array carries no reset; only pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (push_c)
         mem[wr_ptr] <= i_byte;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         o_count    <= '0;
         o_empty    <= 1'b1;
         o_full     <= 1'b0;
         o_overflow <= 1'b0;
         o_tx_byte  <= 8'h00;
         o_tx_dv    <= 1'b0;
         state      <= IDLE;
`ifdef TX_FIFO_CRLF_EN
         lf_pending <= 1'b0;
`endif
      end else begin
         o_tx_dv <= 1'b0;
         if (push_c)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)
            rd_ptr <= rd_ptr + AW'(1);
         o_count <= count_n_c;
         o_empty <= (count_n_c == '0);
         o_full  <= (count_n_c == CW'(DEPTH));
         if (i_byte_v && !push_c)
            o_overflow <= 1'b1;

         case (state)
            IDLE: begin
`ifdef TX_FIFO_CRLF_EN
               if (lf_pending) begin
                  o_tx_byte  <= 8'h0A;
                  lf_pending <= 1'b0;
                  o_tx_dv    <= 1'b1;
                  state      <= LAUNCH;
               end else if (pop_c) begin
                  o_tx_byte  <= (head_c == 8'h0A) ? 8'h0D : head_c;
                  lf_pending <= (head_c == 8'h0A);
                  o_tx_dv    <= 1'b1;
                  state      <= LAUNCH;
               end
`else
               if (pop_c) begin
                  o_tx_byte <= head_c;
                  o_tx_dv   <= 1'b1;
                  state     <= LAUNCH;
               end
`endif
            end
            LAUNCH:
               state <= WAIT_ACT;
            // A done seen before active means the UART already finished the frame.
            WAIT_ACT: begin
               if (i_tx_done)
                  state <= IDLE;
               else if (i_tx_active)
                  state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (i_tx_done)
                  state <= IDLE;
            end
            default:
               state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Directed bench for tx_byte_fifo with a behavioural uart_tx model (1042-cycle frames).
module tb_tx_byte_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int          FRAME = 1042;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [7:0]    i_byte = 8'h00;
   logic          i_byte_v = 1'b0;
   logic [7:0]    o_tx_byte;
   logic          o_tx_dv;
   logic          i_tx_active = 1'b0;
   logic          i_tx_done = 1'b0;
   logic [AW:0]   o_count;
   logic          o_empty;
   logic          o_full;
   logic          o_overflow;

   int errors = 0;
   int checks = 0;

   // UART model and monitors
   int         cyc = 0;
   bit         busy = 1'b0;
   int         cnt = 0;
   logic [7:0] cur_byte = 8'h00;
   bit         stab_chk = 1'b1;
   int         stab_err = 0;
   int         dv_err = 0;
   int         max_cnt = 0;
   logic [7:0] sent[$];
   int         dv_cyc[$];
   int         done_cyc[$];

   tx_byte_fifo #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_byte      (i_byte),
      .i_byte_v    (i_byte_v),
      .o_tx_byte   (o_tx_byte),
      .o_tx_dv     (o_tx_dv),
      .i_tx_active (i_tx_active),
      .i_tx_done   (i_tx_done),
      .o_count     (o_count),
      .o_empty     (o_empty),
      .o_full      (o_full),
      .o_overflow  (o_overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc = cyc + 1;
      i_tx_done = 1'b0;
      if (int'(o_count) > max_cnt)
         max_cnt = int'(o_count);
      if (busy) begin
         if (stab_chk && (o_tx_byte !== cur_byte))
            stab_err = stab_err + 1;
         cnt = cnt - 1;
         if (cnt == 0) begin
            i_tx_done   = 1'b1;
            i_tx_active = 1'b0;
            busy        = 1'b0;
            done_cyc.push_back(cyc);
         end
      end
      if (o_tx_dv === 1'b1) begin
         if (busy) begin
            dv_err = dv_err + 1;
         end else begin
            busy        = 1'b1;
            cnt         = FRAME;
            cur_byte    = o_tx_byte;
            i_tx_active = 1'b1;
            sent.push_back(o_tx_byte);
            dv_cyc.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      i_byte   = b;
      i_byte_v = 1'b1;
      tick();
      i_byte_v = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s: uart still busy after %0d cycles, required idle", tag, budget);
      end
   endtask

   task automatic wait_frames(input int n, input int budget, input string tag);
      int k = 0;
      while ((sent.size() < n || busy) && k < budget) begin
         tick();
         k++;
      end
      checks++;
      if (sent.size() < n || busy) begin
         errors++;
         $display("FAIL %s: got %0d frames in %0d cycles, required %0d", tag, sent.size(), budget, n);
      end
   endtask

   task automatic do_reset();
      stab_chk = 1'b0;
      i_byte_v = 1'b0;
      rst      = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      wait_idle(FRAME + 100, "reset_idle");
      sent.delete();
      dv_cyc.delete();
      done_cyc.delete();
      stab_err = 0;
      dv_err   = 0;
      stab_chk = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      checks++;
      if (o_empty !== 1'b1 || o_count !== 5'd0 || o_full !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: empty=%b count=%0d full=%b, required 1/0/0", o_empty, o_count, o_full);
      end
      checks++;
      if (o_overflow !== 1'b0 || o_tx_byte !== 8'h00 || o_tx_dv !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: ovf=%b byte=%h dv=%b, required 0/00/0", o_overflow, o_tx_byte, o_tx_dv);
      end
      repeat (20) tick();
      checks++;
      if (sent.size() != 0) begin
         errors++;
         $display("FAIL reset_no_dv: %0d dv pulses, required 0", sent.size());
      end
   endtask

   task automatic test_single();
      push(8'h41);
      checks++;
      if (o_count !== 5'd1 || o_empty !== 1'b0 || o_tx_dv !== 1'b0) begin
         errors++;
         $display("FAIL single_n1: count=%0d empty=%b dv=%b, required 1/0/0", o_count, o_empty, o_tx_dv);
      end
      tick();
      checks++;
      if (o_tx_dv !== 1'b1 || o_tx_byte !== 8'h41) begin
         errors++;
         $display("FAIL single_n2: dv=%b byte=%h, required 1/41", o_tx_dv, o_tx_byte);
      end
      checks++;
      if (o_count !== 5'd0 || o_empty !== 1'b1) begin
         errors++;
         $display("FAIL single_pop: count=%0d empty=%b, required 0/1", o_count, o_empty);
      end
      wait_idle(FRAME + 50, "single_done");
      repeat (10) tick();
      checks++;
      if (sent.size() != 1 || dv_err != 0 || stab_err != 0) begin
         errors++;
         $display("FAIL single_frame: frames=%0d dv_err=%0d stab_err=%0d, required 1/0/0", sent.size(), dv_err, stab_err);
      end
   endtask

   task automatic test_full_push_pop();
      int n = 0;
      for (int i = 0; i < 17; i++)
         push(8'h10 + 8'(i));
      checks++;
      if (o_full !== 1'b1 || o_count !== 5'd16 || o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL fpp_fill: full=%b count=%0d ovf=%b, required 1/16/0", o_full, o_count, o_overflow);
      end
      while (i_tx_done !== 1'b1 && n < FRAME + 50) begin
         tick();
         n++;
      end
      tick();
      push(8'hEE);
      checks++;
      if (o_count !== 5'd16 || o_full !== 1'b1 || o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL fpp_both: count=%0d full=%b ovf=%b, required 16/1/0", o_count, o_full, o_overflow);
      end
      checks++;
      if (o_tx_dv !== 1'b1 || o_tx_byte !== 8'h11) begin
         errors++;
         $display("FAIL fpp_launch: dv=%b byte=%h, required 1/11", o_tx_dv, o_tx_byte);
      end
      do_reset();
   endtask

   task automatic test_burst();
      for (int i = 0; i < DEPTH + 2; i++)
         push(8'h80 + 8'(i));
      checks++;
      if (o_full !== 1'b1 || o_count !== 5'd16 || o_overflow !== 1'b1) begin
         errors++;
         $display("FAIL burst_full: full=%b count=%0d ovf=%b, required 1/16/1", o_full, o_count, o_overflow);
      end
      wait_frames(DEPTH + 1, (DEPTH + 2) * (FRAME + 10), "burst_drain");
      repeat (10) tick();
      checks++;
      if (sent.size() != DEPTH + 1) begin
         errors++;
         $display("FAIL burst_frames: got %0d, required %0d", sent.size(), DEPTH + 1);
      end
      for (int k = 0; k < DEPTH + 1; k++) begin
         checks++;
         if (sent[k] !== 8'h80 + 8'(k)) begin
            errors++;
            $display("FAIL burst_order[%0d]: got %h, required %h", k, sent[k], 8'h80 + 8'(k));
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         checks++;
         if (dv_cyc[k + 1] - done_cyc[k] != 2) begin
            errors++;
            $display("FAIL burst_gap[%0d]: got %0d cycles, required 2", k, dv_cyc[k + 1] - done_cyc[k]);
         end
      end
      checks++;
      if (o_overflow !== 1'b1 || o_empty !== 1'b1 || stab_err != 0 || dv_err != 0) begin
         errors++;
         $display("FAIL burst_end: ovf=%b empty=%b stab_err=%0d dv_err=%0d, required 1/1/0/0", o_overflow, o_empty, stab_err, dv_err);
      end
      do_reset();
      checks++;
      if (o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_cleared: got %b, required 0", o_overflow);
      end
   endtask

   task automatic test_wrap();
      max_cnt = 0;
      for (int i = 0; i < 3 * DEPTH; i++) begin
         push(8'(i));
         wait_frames(i + 1, FRAME + 50, "wrap_frame");
      end
      for (int k = 0; k < 3 * DEPTH; k++) begin
         checks++;
         if (sent[k] !== 8'(k)) begin
            errors++;
            $display("FAIL wrap_order[%0d]: got %h, required %h", k, sent[k], 8'(k));
         end
      end
      checks++;
      if (max_cnt != 1 || stab_err != 0 || dv_err != 0) begin
         errors++;
         $display("FAIL wrap_count: max=%0d stab_err=%0d dv_err=%0d, required 1/0/0", max_cnt, stab_err, dv_err);
      end
      do_reset();
   endtask

   task automatic test_crlf();
      logic [7:0] exp[$];
`ifdef TX_FIFO_CRLF_EN
      exp = '{8'h48, 8'h0D, 8'h0A, 8'h0D};
`else
      exp = '{8'h48, 8'h0A, 8'h0D};
`endif
      push(8'h48);
      push(8'h0A);
      push(8'h0D);
      wait_frames(exp.size(), 5 * (FRAME + 10), "crlf_drain");
      repeat (10) tick();
      checks++;
      if (sent.size() != exp.size()) begin
         errors++;
         $display("FAIL crlf_frames: got %0d, required %0d", sent.size(), exp.size());
      end
      for (int k = 0; k < exp.size(); k++) begin
         checks++;
         if (sent[k] !== exp[k]) begin
            errors++;
            $display("FAIL crlf_order[%0d]: got %h, required %h", k, sent[k], exp[k]);
         end
      end
      checks++;
      if (o_empty !== 1'b1 || o_count !== 5'd0) begin
         errors++;
         $display("FAIL crlf_empty: empty=%b count=%0d, required 1/0", o_empty, o_count);
      end
      do_reset();
   endtask

   task automatic test_reset_mid();
      int n0;
      for (int i = 0; i < 6; i++)
         push(8'h60 + 8'(i));
      tick();
      tick();
      checks++;
      if (i_tx_active !== 1'b1 || o_count !== 5'd5) begin
         errors++;
         $display("FAIL mid_pre: active=%b count=%0d, required 1/5", i_tx_active, o_count);
      end
      stab_chk = 1'b0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++;
      if (o_count !== 5'd0 || o_empty !== 1'b1 || o_full !== 1'b0 || o_tx_dv !== 1'b0 || o_tx_byte !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset: count=%0d empty=%b full=%b dv=%b byte=%h, required 0/1/0/0/00",
                  o_count, o_empty, o_full, o_tx_dv, o_tx_byte);
      end
      n0 = sent.size();
      wait_idle(FRAME + 50, "mid_uart");
      repeat (20) tick();
      checks++;
      if (sent.size() != n0 || o_empty !== 1'b1) begin
         errors++;
         $display("FAIL mid_quiet: frames %0d->%0d empty=%b, required no new frames, empty 1", n0, sent.size(), o_empty);
      end
      stab_chk = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_full_push_pop();
      test_burst();
      test_wrap();
      test_crlf();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
